apb_fnd_ctrl: RTL and testbench

APB-mapped controller for the 4-digit 7-segment (FND) display. Software writes a binary value and control bits over APB. The block converts the value to BCD with a sequential double-dabble engine and holds the result in a display buffer. It time-multiplexes the four digits with a programmable scan rate, and supports optional leading-zero blanking, blink and per-digit decimal points. It sits on the peripheral APB bus next to the other slaves and drives the board's `fndCom`/`fndFont` pins directly.

---
 rtl/fnd_pkg.sv | 43 ++++
 rtl/apb_fnd_ctrl_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 56 +++++
 rtl/apb_fnd_ctrl.sv | 139 +++++++++++++
 tb/tb_apb_fnd_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the APB 7-segment display controller:
// register offsets, CR bit positions, conversion states and font table.
package fnd_pkg;

  localparam logic [3:0] FND_CR  = 4'h0;
  localparam logic [3:0] FND_ODR = 4'h4;
  localparam logic [3:0] FND_DPR = 4'h8;
  localparam logic [3:0] FND_SR  = 4'hC;

  localparam int CR_EN    = 0;
  localparam int CR_BLINK = 1;
  localparam int CR_LZ    = 2;

  localparam logic [7:0]  FND_BLANK = 8'hFF;
  localparam logic [13:0] FND_MAX   = 14'd9999;

  typedef enum logic {IDLE, SHIFT} conv_state_e;

  // Active-low {g..a} glyphs for hex digits
  function automatic logic [6:0] fnd_font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/apb_fnd_ctrl_if.sv
// APB slave bus bundle for the display controller.
interface apb_fnd_ctrl_if;

  logic [3:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14 add-3/shift iterations, one per clock.
// A new start during SHIFT restarts with the new operand.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_e state_q;
  logic [13:0] sh_q;
  logic [15:0] acc_q;
  logic [3:0]  cnt_q;
  logic [15:0] adj;
  logic [29:0] nxt;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (acc_q[i*4 +: 4] >= 4'd5)
                    ? acc_q[i*4 +: 4] + 4'd3
                    : acc_q[i*4 +: 4];
    end
    nxt = {adj, sh_q} << 1;
  end

  assign busy = (state_q == SHIFT);
  assign bcd  = nxt[29:14];
  // A restart on the final iteration suppresses the stale result
  assign done = busy && (cnt_q == 4'd13) && !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      state_q <= SHIFT;
      sh_q    <= bin;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      sh_q  <= nxt[13:0];
      acc_q <= nxt[29:14];
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd13) state_q <= IDLE;
    end
  end

endmodule

// File: rtl/apb_fnd_ctrl.sv
// APB-mapped 4-digit 7-segment controller: register file, BCD
// conversion, digit scan, blink and leading-zero blanking.
module apb_fnd_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_fnd_ctrl_if.slave        bus,
  output logic [3:0]           fndCom,
  output logic [7:0]           fndFont
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [2:0]    cr_q, cr_d;
  logic [31:0]   odr_q, odr_d;
  logic [3:0]    dpr_q, dpr_d;
  logic [15:0]   buf_q, buf_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [1:0]    idx_q, idx_d;
  logic          ph_q, ph_d;

  logic        acc, wr, tick, start;
  logic        hit_cr, hit_odr, hit_dpr, hit_sr;
  logic [13:0] bin;
  logic        busy, done;
  logic [15:0] bcd;
  logic        unused_bits;

  assign acc     = bus.PSEL & bus.PENABLE;
  assign wr      = acc & bus.PWRITE;
  assign hit_cr  = bus.PADDR[3:2] == FND_CR[3:2];
  assign hit_odr = bus.PADDR[3:2] == FND_ODR[3:2];
  assign hit_dpr = bus.PADDR[3:2] == FND_DPR[3:2];
  assign hit_sr  = bus.PADDR[3:2] == FND_SR[3:2];
  assign start   = wr & hit_odr;
  assign bin     = (bus.PWDATA > 32'd9999) ? FND_MAX
                                           : bus.PWDATA[13:0];
  assign tick    = div_q == DW'(SCAN_DIV - 1);
  assign bus.PREADY = acc;
  assign unused_bits = ^bus.PADDR[1:0];

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    cr_d  = cr_q;
    odr_d = odr_q;
    dpr_d = dpr_q;
    if (wr) begin
      unique case (1'b1)
        hit_cr:  cr_d  = bus.PWDATA[2:0];
        hit_odr: odr_d = bus.PWDATA;
        hit_dpr: dpr_d = bus.PWDATA[3:0];
        default: ;
      endcase
    end
    buf_d = done ? bcd : buf_q;
    div_d = tick ? '0 : div_q + DW'(1);
    idx_d = idx_q + {1'b0, tick};
    blk_d = blk_q;
    ph_d  = ph_q;
    if (!cr_q[CR_BLINK]) begin
      blk_d = '0;
      ph_d  = 1'b0;
    end else if (tick) begin
      if (blk_q == BW'(BLINK_DIV - 1)) begin
        blk_d = '0;
        ph_d  = ~ph_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end
  end

  always_comb begin
    bus.PRDATA = '0;
    if (acc) begin
      unique case (1'b1)
        hit_cr:  bus.PRDATA = {29'd0, cr_q};
        hit_odr: bus.PRDATA = odr_q;
        hit_dpr: bus.PRDATA = {28'd0, dpr_q};
        hit_sr:  bus.PRDATA = {31'd0, busy};
        default: bus.PRDATA = '0;
      endcase
    end
  end

  logic [15:0] hi;
  logic [3:0]  nib;
  logic        blank;

  // Digit is a leading zero when it and every digit above are zero
  always_comb begin
    hi    = buf_q >> {idx_q, 2'b00};
    nib   = hi[3:0];
    blank = !cr_q[CR_EN]
          || (cr_q[CR_BLINK] && ph_q)
          || (cr_q[CR_LZ] && idx_q != 2'd0 && hi == 16'd0);
    fndCom  = blank ? 4'hF : ~(4'b0001 << idx_q);
    fndFont = blank ? FND_BLANK
                    : {~dpr_q[idx_q], fnd_font(nib)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr_q  <= '0;
      odr_q <= '0;
      dpr_q <= '0;
      buf_q <= '0;
      div_q <= '0;
      blk_q <= '0;
      idx_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cr_q  <= cr_d;
      odr_q <= odr_d;
      dpr_q <= dpr_d;
      buf_q <= buf_d;
      div_q <= div_d;
      blk_q <= blk_d;
      idx_q <= idx_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: tb/tb_apb_fnd_ctrl.sv
// Self-checking bench for apb_fnd_ctrl with a fast scan and blink.
// Expected scan slots are queued per scenario and drained against the pins.
module tb_apb_fnd_ctrl;
  import fnd_pkg::*;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
  } scan_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fndCom;
  logic [7:0] fndFont;
  int         checks = 0;
  int         errors = 0;
  scan_t      sb[$];

  apb_fnd_ctrl_if bus();

  apb_fnd_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .fndCom  (fndCom),
    .fndFont (fndFont)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  // Entered and left on a negedge; commit happens on the posedge between
  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge clk); bus.PENABLE = 1'b1;
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a,
                        output logic [31:0] d, output logic rdy);
    bus.PADDR = a; bus.PWRITE = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    @(negedge clk); bus.PENABLE = 1'b1;
    #1; d = bus.PRDATA; rdy = bus.PREADY;
    @(negedge clk); bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Wait until (fndCom == c) == eq, bounded by a cycle budget
  task automatic wait_com(input logic [3:0] c, input logic eq,
                          input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if ((fndCom == c) == eq) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  function automatic int com2idx(input logic [3:0] c);
    case (c)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic r;
    repeat (3) @(negedge clk);
    checks++;
    if ({fndCom, fndFont, bus.PREADY, bus.PRDATA} !==
        {4'hF, 8'hFF, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_out: com=%h font=%h rdy=%b rd=%h want F FF 0 0",
               fndCom, fndFont, bus.PREADY, bus.PRDATA);
    end
    reset = 1'b0;
    for (int n = 0; n < 64; n++) begin
      checks++;
      if ({fndCom, fndFont} !== {4'hF, 8'hFF}) begin
        errors++;
        $display("FAIL idle_blank[%0d]: com=%h font=%h want F FF",
                 n, fndCom, fndFont);
      end
      @(negedge clk);
    end
    bus.PADDR = FND_SR; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
    #1;
    checks++;
    if ({bus.PREADY, bus.PRDATA} !== 33'd0) begin
      errors++;
      $display("FAIL setup_phase: rdy=%b rd=%h want 0 0",
               bus.PREADY, bus.PRDATA);
    end
    @(negedge clk); bus.PSEL = 1'b0;
    foreach (sb[i]) sb.delete(i);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] a;
      a = (k == 0) ? FND_SR : (k == 1) ? FND_CR : FND_ODR;
      apb_rd(a, d, r);
      checks++;
      if ({r, d} !== {1'b1, 32'd0}) begin
        errors++;
        $display("FAIL reset_reg[%h]: rdy=%b rd=%h want 1 0", a, r, d);
      end
    end
  endtask

  task automatic test_convert();
    logic ok;
    scan_t e;
    int cnt;
    apb_wr(FND_CR, 32'd1);
    apb_wr(FND_ODR, 32'd1234);
    bus.PADDR = FND_SR; bus.PWRITE = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.PRDATA[0] !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    @(negedge clk); bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    checks++;
    if (cnt != 14) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles want 14", cnt);
    end
    sb.push_back('{4'hE, 8'h99});
    sb.push_back('{4'hD, 8'hB0});
    sb.push_back('{4'hB, 8'hA4});
    sb.push_back('{4'h7, 8'hF9});
    wait_com(4'hE, 1'b0, 40, ok);
    if (ok) wait_com(4'hE, 1'b1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_sync_1234: got timeout want slot0");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      repeat (4) begin
        checks++;
        if ({fndCom, fndFont} !== {e.com, e.font}) begin
          errors++;
          $display("FAIL scan_1234: got %h/%h want %h/%h",
                   fndCom, fndFont, e.com, e.font);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_saturate();
    logic ok, r;
    logic [31:0] d;
    scan_t e;
    apb_wr(FND_ODR, 32'd20000);
    repeat (16) @(negedge clk);
    apb_rd(FND_ODR, d, r);
    checks++;
    if (d !== 32'd20000) begin
      errors++;
      $display("FAIL odr_readback: got %0d want 20000", d);
    end
    sb.push_back('{4'hE, 8'h90});
    sb.push_back('{4'hD, 8'h90});
    sb.push_back('{4'hB, 8'h90});
    sb.push_back('{4'h7, 8'h90});
    wait_com(4'hE, 1'b0, 40, ok);
    if (ok) wait_com(4'hE, 1'b1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_sync_sat: got timeout want slot0");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      repeat (4) begin
        checks++;
        if ({fndCom, fndFont} !== {e.com, e.font}) begin
          errors++;
          $display("FAIL scan_sat: got %h/%h want %h/%h",
                   fndCom, fndFont, e.com, e.font);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    scan_t e;
    logic [7:0] t42 [4];
    logic [7:0] want;
    int i;
    t42[0] = 8'hA4; t42[1] = 8'h99; t42[2] = 8'hC0; t42[3] = 8'hC0;
    apb_wr(FND_ODR, 32'd5678);
    apb_wr(FND_ODR, 32'd42);
    // Old 9999 holds for 14 cycles, then 0042 with no 5678 in between
    for (int n = 0; n < 30; n++) begin
      i = com2idx(fndCom);
      want = (n < 14) ? 8'h90 : ((i < 0) ? 8'hXX : t42[i]);
      checks++;
      if (i < 0 || fndFont !== want) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%h want font %h",
                 n, fndCom, fndFont, want);
      end
      @(negedge clk);
    end
    apb_wr(FND_CR, 32'd5);
    sb.push_back('{4'hE, 8'hA4});
    sb.push_back('{4'hD, 8'h99});
    sb.push_back('{4'hF, 8'hFF});
    sb.push_back('{4'hF, 8'hFF});
    wait_com(4'hE, 1'b0, 40, ok);
    if (ok) wait_com(4'hE, 1'b1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_sync_lz: got timeout want slot0");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      repeat (4) begin
        checks++;
        if ({fndCom, fndFont} !== {e.com, e.font}) begin
          errors++;
          $display("FAIL scan_lz: got %h/%h want %h/%h",
                   fndCom, fndFont, e.com, e.font);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_dp();
    logic ok;
    scan_t e;
    apb_wr(FND_CR, 32'd1);
    apb_wr(FND_DPR, 32'h4);
    sb.push_back('{4'hE, 8'hA4});
    sb.push_back('{4'hD, 8'h99});
    sb.push_back('{4'hB, 8'h40});
    sb.push_back('{4'h7, 8'hC0});
    wait_com(4'hE, 1'b0, 40, ok);
    if (ok) wait_com(4'hE, 1'b1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_sync_dp: got timeout want slot0");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      repeat (4) begin
        checks++;
        if ({fndCom, fndFont} !== {e.com, e.font}) begin
          errors++;
          $display("FAIL scan_dp: got %h/%h want %h/%h",
                   fndCom, fndFont, e.com, e.font);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blink();
    logic ok, eb;
    apb_wr(FND_CR, 32'd3);
    wait_com(4'hF, 1'b1, 40, ok);
    if (ok) wait_com(4'hF, 1'b0, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL blink_sync: got timeout want phase edge");
    end
    for (int n = 0; n < 24; n++) begin
      eb = ((n / 8) % 2) == 1;
      checks++;
      if ({fndCom == 4'hF, fndFont == 8'hFF} !== {eb, eb}) begin
        errors++;
        $display("FAIL blink[%0d]: got %h/%h want blank=%b",
                 n, fndCom, fndFont, eb);
      end
      @(negedge clk);
    end
    wait_com(4'hF, 1'b1, 40, ok);
    apb_wr(FND_CR, 32'd1);
    checks++;
    if (!ok || fndCom == 4'hF || fndFont == 8'hFF) begin
      errors++;
      $display("FAIL blink_off: got %h/%h sync=%b want shown",
               fndCom, fndFont, ok);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic r;
    apb_wr(FND_ODR, 32'd1234);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apb_rd(FND_SR, d, r);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL abort_sr: got %h want 0", d);
    end
    apb_wr(FND_CR, 32'd1);
    repeat (20) @(negedge clk);
    checks++;
    if (fndCom == 4'hF || fndFont !== 8'hC0) begin
      errors++;
      $display("FAIL abort_buf: got %h/%h want digit font C0",
               fndCom, fndFont);
    end
  endtask

  initial begin
    bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0; bus.PWDATA = '0;
    test_reset();
    test_convert();
    test_saturate();
    test_back_to_back();
    test_dp();
    test_blink();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
